// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the FSM state type, parity-mode encodings and the parameter-legality check.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic bit uart_cfg_legal(input int unsigned cpb, input int unsigned db,
                                          input int unsigned pm, input int unsigned sb);
        return (cpb >= 8) && (cpb <= 65535) && (db >= 5) && (db <= 9) &&
               (pm <= PAR_EVEN) && ((sb == 1) || (sb == 2));
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote around the bit centre.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the mid+1 value, so the decision lands one clock after the centre.
    localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2 + 1);
`else
    localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
`endif
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (!uart_cfg_legal(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS)) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic rx_sync;
    logic samp;

    uart_sync2 u_sync (
        .clk_i  (i_Clock),
        .rst_ni (i_Rst_L),
        .d_i    (i_RX_Serial),
        .q_o    (rx_sync)
    );

`ifdef UART_RX_MAJORITY_EN
    if (CLKS_PER_BIT < 8) begin : g_bad_maj
        $error("uart_rx_cfg: majority sampling needs CLKS_PER_BIT >= 8");
    end

    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= rx_sync;
            hist2_q <= hist1_q;
        end
    end

    assign samp = (rx_sync & hist1_q) | (rx_sync & hist2_q) | (hist1_q & hist2_q);
`else
    assign samp = rx_sync;
`endif

    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 ferr_acc_q;
    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 perr_calc;
    logic                 ferr_calc;

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY_MODE == PAR_ODD) begin
            perr_calc = (^{shift_q, par_bit_q}) != 1'b1;
        end else if (PARITY_MODE == PAR_EVEN) begin
            perr_calc = (^{shift_q, par_bit_q}) != 1'b0;
        end
    end

    assign ferr_calc = ferr_acc_q | ~samp;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_sync) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q      <= '0;
                        ferr_acc_q <= 1'b0;
                        state_q    <= samp ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {samp, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_MODE != PAR_NONE) ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StParity: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_bit_q <= samp;
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            dv_q      <= 1'b1;
                            byte_q    <= shift_q;
                            perr_q    <= perr_calc;
                            ferr_q    <= ferr_calc;
                            state_q   <= ferr_calc ? StWaitHigh : StIdle;
                        end else begin
                            ferr_acc_q <= ferr_calc;
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StWaitHigh: begin
                    // Break handling: any low restarts the full-bit high qualification.
                    if (!rx_sync) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, scoreboard-checked.
module tb_uart_rx_cfg;

    localparam int CPB_A = 217;
    localparam int CPB_B = 16;
    localparam int MID_A = (CPB_A - 1) / 2;
    localparam int MID_B = (CPB_B - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [15:0] SPIKE_B = 16'h00FE;
`else
    localparam int MAJ = 0;
    localparam logic [15:0] SPIKE_B = 16'h0000;
`endif
    localparam int LAT_A = 4 + MID_A + 9 * CPB_A + MAJ;
    localparam int LAT_B = 4 + MID_B + 10 * CPB_B + MAJ;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a;
    logic       rx_b;
    logic       dv_a, perr_a, ferr_a, busy_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, ferr_b, busy_b;
    logic [6:0] byte_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dv_cyc_a = 0;
    int   dv_cyc_b = 0;
    logic dv_a_prev = 1'b0;
    logic dv_b_prev = 1'b0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(
        .CLKS_PER_BIT (CPB_A),
        .DATA_BITS    (8),
        .PARITY_MODE  (0),
        .STOP_BITS    (1)
    ) dut_a (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_RX_Serial  (rx_a),
        .o_RX_DV      (dv_a),
        .o_RX_Byte    (byte_a),
        .o_Parity_Err (perr_a),
        .o_Frame_Err  (ferr_a),
        .o_Busy       (busy_a)
    );

    uart_rx_cfg #(
        .CLKS_PER_BIT (CPB_B),
        .DATA_BITS    (7),
        .PARITY_MODE  (2),
        .STOP_BITS    (2)
    ) dut_b (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_RX_Serial  (rx_b),
        .o_RX_DV      (dv_b),
        .o_RX_Byte    (byte_b),
        .o_Parity_Err (perr_b),
        .o_Frame_Err  (ferr_b),
        .o_Busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits line bits LSB first, each for cpb clocks, starting at the current negedge.
    task automatic drive_bits(input bit sel_b, input logic [15:0] bits, input int nbits,
                              input int cpb, input logic [15:0] spike);
        logic v;
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < cpb; j++) begin
                v = bits[k];
                if (spike[k] && (j == (cpb - 1) / 2 + 1)) v = ~v;
                if (sel_b) rx_b = v;
                else rx_a = v;
                @(negedge clk);
            end
        end
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic par);
        return {5'b0, 2'b11, par, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (dv_a) begin
            dv_cyc_a = cyc;
            check("a_dv_width", {31'b0, dv_a_prev}, 32'd0);
            check("a_dv_expected", {31'b0, (exp_a.size() != 0)}, 32'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_byte", {24'b0, byte_a}, {23'b0, e.data});
                check("a_perr", {31'b0, perr_a}, {31'b0, e.perr});
                check("a_ferr", {31'b0, ferr_a}, {31'b0, e.ferr});
            end
        end
        dv_a_prev = dv_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (dv_b) begin
            dv_cyc_b = cyc;
            check("b_dv_width", {31'b0, dv_b_prev}, 32'd0);
            check("b_dv_expected", {31'b0, (exp_b.size() != 0)}, 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_byte", {25'b0, byte_b}, {23'b0, e.data});
                check("b_perr", {31'b0, perr_b}, {31'b0, e.perr});
                check("b_ferr", {31'b0, ferr_b}, {31'b0, e.ferr});
            end
        end
        dv_b_prev = dv_b;
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        wait_clks(3);
        check("rst_a_dv", {31'b0, dv_a}, 32'd0);
        check("rst_a_byte", {24'b0, byte_a}, 32'd0);
        check("rst_a_perr", {31'b0, perr_a}, 32'd0);
        check("rst_a_ferr", {31'b0, ferr_a}, 32'd0);
        check("rst_a_busy", {31'b0, busy_a}, 32'd0);
        check("rst_b_dv", {31'b0, dv_b}, 32'd0);
        check("rst_b_byte", {25'b0, byte_b}, 32'd0);
        check("rst_b_busy", {31'b0, busy_b}, 32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        // Plain 8N1 frame plus stop-centre to DV latency.
        exp_a.push_back('{data: 9'h37, perr: 1'b0, ferr: 1'b0});
        c0 = cyc;
        drive_bits(1'b0, frame_a(8'h37, 1'b1), 10, CPB_A, 16'h0);
        check("a_latency", dv_cyc_a - c0, LAT_A);
        check("a_busy_after", {31'b0, busy_a}, 32'd0);
        wait_clks(50);

        // 20-clock glitch on an idle line is a false start.
        c0 = cyc;
        rx_a = 1'b0;
        wait_clks(10);
        check("glitch_busy_hi", {31'b0, busy_a}, 32'd1);
        wait_clks(10);
        rx_a = 1'b1;
        wait_clks(3 + MID_A - 20);
        check("glitch_busy_pre_mid", {31'b0, busy_a}, 32'd1);
        wait_clks(2);
        check("glitch_busy_lo", {31'b0, busy_a}, 32'd0);
        check("glitch_byte_hold", {24'b0, byte_a}, 32'h37);
        wait_clks(CPB_A);

        // Frame error, line held low (break), then a clean frame.
        exp_a.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b1});
        drive_bits(1'b0, frame_a(8'hA5, 1'b0), 10, CPB_A, 16'h0);
        rx_a = 1'b0;
        wait_clks(CPB_A);
        check("break_busy", {31'b0, busy_a}, 32'd1);
        check("break_ferr_hold", {31'b0, ferr_a}, 32'd1);
        check("break_byte_hold", {24'b0, byte_a}, 32'hA5);
        wait_clks(2 * CPB_A);
        rx_a = 1'b1;
        wait_clks(2 * CPB_A);
        check("break_idle", {31'b0, busy_a}, 32'd0);
        exp_a.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0});
        drive_bits(1'b0, frame_a(8'h5A, 1'b1), 10, CPB_A, 16'h0);
        wait_clks(CPB_A);
        check("a_ferr_cleared", {31'b0, ferr_a}, 32'd0);

        // Reset during data bit 3 of 0xC3, then 0x3C.
        drive_bits(1'b0, frame_a(8'hC3, 1'b1), 4, CPB_A, 16'h0);
        rx_a = 1'b0;
        wait_clks(100);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        wait_clks(3);
        check("midrst_dv", {31'b0, dv_a}, 32'd0);
        check("midrst_byte", {24'b0, byte_a}, 32'd0);
        check("midrst_perr", {31'b0, perr_a}, 32'd0);
        check("midrst_ferr", {31'b0, ferr_a}, 32'd0);
        check("midrst_busy", {31'b0, busy_a}, 32'd0);
        rst_n = 1'b1;
        wait_clks(10);
        exp_a.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b0});
        drive_bits(1'b0, frame_a(8'h3C, 1'b1), 10, CPB_A, 16'h0);
        wait_clks(CPB_A);

        // Even parity: correct bit, then wrong bit, back to back.
        exp_b.push_back('{data: 9'h073, perr: 1'b0, ferr: 1'b0});
        exp_b.push_back('{data: 9'h073, perr: 1'b1, ferr: 1'b0});
        c0 = cyc;
        drive_bits(1'b1, frame_b(7'h73, 1'b1), 11, CPB_B, 16'h0);
        check("b_latency", dv_cyc_b - c0, LAT_B);
        drive_bits(1'b1, frame_b(7'h73, 1'b0), 11, CPB_B, 16'h0);
        wait_clks(3 * CPB_B);
        check("b_perr_hold", {31'b0, perr_b}, 32'd1);
        check("b_busy_after", {31'b0, busy_b}, 32'd0);

        // Back-to-back 7E2 frames, spiked at each data centre when voting is enabled.
        exp_b.push_back('{data: 9'h015, perr: 1'b0, ferr: 1'b0});
        exp_b.push_back('{data: 9'h06A, perr: 1'b0, ferr: 1'b0});
        drive_bits(1'b1, frame_b(7'h15, ^7'h15), 11, CPB_B, SPIKE_B);
        drive_bits(1'b1, frame_b(7'h6A, ^7'h6A), 11, CPB_B, SPIKE_B);
        wait_clks(3 * CPB_B);
        check("b_byte_hold", {25'b0, byte_b}, 32'h6A);

        check("a_sb_drained", exp_a.size(), 32'd0);
        check("b_sb_drained", exp_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
